// File: rtl/ps2_keys_pkg.sv
// ============================================================================
// Module   : ps2_keys_pkg
// Brief    : Shared types and constants for the PS/2 set-2 key tracker:
//            prefix-FSM state encoding, prefix bytes, ignored bytes and
//            common scan codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_keys_pkg;

  // Prefix decoder states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } scan_state_e;

  // Prefix bytes
  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  // Controller / keyboard housekeeping bytes that never carry a key code
  localparam logic [7:0] IGN_BAT_OK = 8'hAA;
  localparam logic [7:0] IGN_ACK    = 8'hFA;
  localparam logic [7:0] IGN_RESEND = 8'hFE;
  localparam logic [7:0] IGN_ECHO   = 8'hEE;
  localparam logic [7:0] IGN_ERR0   = 8'h00;
  localparam logic [7:0] IGN_ERRF   = 8'hFF;

  // Common scan codes
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;

  // True for bytes that are dropped without touching the decoder state
  function automatic logic is_ignored_byte(input logic [7:0] b);
    return (b == IGN_BAT_OK) || (b == IGN_ACK)  || (b == IGN_RESEND) ||
           (b == IGN_ECHO)   || (b == IGN_ERR0) || (b == IGN_ERRF);
  endfunction

endpackage : ps2_keys_pkg

`default_nettype wire

// File: rtl/ps2_scan_fsm.sv
// ============================================================================
// Module   : ps2_scan_fsm
// Brief    : PS/2 set-2 prefix decoder. Tracks E0/F0 prefixes and emits one
//            decoded code per completed make/break sequence. The code event
//            is combinational on the strobe cycle so the key registers in the
//            parent can present results one cycle after the final byte.
//            Optional prefix timeout enabled by macro PS2_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_scan_fsm
  import ps2_keys_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       code_valid_o,
  output logic [7:0] code_o,
  output logic       is_ext_o,
  output logic       is_break_o,
  output logic       proto_timeout_o
);

  scan_state_e state_q;
  scan_state_e state_d;

  // Next-state and decoded-code event for the current strobe
  always_comb begin
    state_d      = state_q;
    code_valid_o = 1'b0;
    is_ext_o     = 1'b0;
    is_break_o   = 1'b0;
    if (valid_i && !is_ignored_byte(data_i)) begin
      case (state_q)
        ST_IDLE: begin
          if (data_i == PREFIX_EXT)      state_d = ST_EXT;
          else if (data_i == PREFIX_BRK) state_d = ST_BRK;
          else                           code_valid_o = 1'b1;
        end
        ST_EXT: begin
          if (data_i == PREFIX_BRK)      state_d = ST_EXT_BRK;
          else if (data_i == PREFIX_EXT) state_d = ST_EXT;
          else begin
            code_valid_o = 1'b1;
            is_ext_o     = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (data_i == PREFIX_EXT)      state_d = ST_EXT;
          else if (data_i == PREFIX_BRK) state_d = ST_BRK;
          else begin
            code_valid_o = 1'b1;
            is_break_o   = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (data_i == PREFIX_EXT)      state_d = ST_EXT;
          else if (data_i == PREFIX_BRK) state_d = ST_EXT_BRK;
          else begin
            code_valid_o = 1'b1;
            is_ext_o     = 1'b1;
            is_break_o   = 1'b1;
            state_d      = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign code_o = data_i;

`ifdef PS2_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  // State register plus prefix watchdog: abandon a stalled prefix sequence
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (valid_i || (state_q == ST_IDLE)) begin
        state_q <= state_d;
        cnt_q   <= '0;
      end else if (cnt_q == CNT_LAST) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        timeout_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign proto_timeout_o = timeout_q;
`else
  // State register; a prefix state waits indefinitely for its next byte
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign proto_timeout_o    = 1'b0;
`endif

endmodule : ps2_scan_fsm

`default_nettype wire

// File: rtl/ps2_key_tracker.sv
// ============================================================================
// Module   : ps2_key_tracker
// Brief    : PS/2 set-2 key tracker. Decodes the byte stream from the PS/2
//            controller and keeps held state plus press/release pulses for a
//            parameterised table of keys. Typematic repeats produce no pulse.
//            Optional prefix timeout enabled by macro PS2_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_tracker
  import ps2_keys_pkg::*;
#(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {SC_UP, SC_SPACE, SC_ESC, SC_ENTER},
  parameter logic [NUM_KEYS-1:0]   KEY_EXT        = 4'b1000,
  parameter int                    TIMEOUT_CYCLES = 100_000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press_pulse,
  output logic [NUM_KEYS-1:0] key_release_pulse,
  output logic                any_key_held,
  output logic                proto_timeout
);

  logic          code_valid;
  logic [7:0]    code;
  logic          is_ext;
  logic          is_break;
  logic [NUM_KEYS-1:0] held_d;
  logic          any_q;

  ps2_scan_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_scan_fsm (
    .clk_i           (CLOCK_50),
    .rst_i           (reset),
    .data_i          (received_data),
    .valid_i         (received_data_en),
    .code_valid_o    (code_valid),
    .code_o          (code),
    .is_ext_o        (is_ext),
    .is_break_o      (is_break),
    .proto_timeout_o (proto_timeout)
  );

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic match;
    logic held_q;
    logic press_q;
    logic release_q;

    // Duplicate table entries all match, so each key decides independently
    assign match     = code_valid && (code == KEY_CODES[i*8 +: 8]) && (is_ext == KEY_EXT[i]);
    assign held_d[i] = match ? !is_break : held_q;

    // Held state and edge pulses; a make on a held key is a typematic repeat
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        held_q    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        held_q    <= held_d[i];
        press_q   <= match && !is_break && !held_q;
        release_q <= match &&  is_break &&  held_q;
      end
    end

    assign key_held[i]          = held_q;
    assign key_press_pulse[i]   = press_q;
    assign key_release_pulse[i] = release_q;
  end

  // Registered OR of the next held vector so it lines up with key_held
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) any_q <= 1'b0;
    else       any_q <= |held_d;
  end

  assign any_key_held = any_q;

endmodule : ps2_key_tracker

`default_nettype wire
